iob_s2f_bus_ctrl: RTL and testbench
===================================

// Module: iob_s2f_bus_ctrl
// PURPOSE
//   Fast-domain controller that moves a multi-bit word from a slow/async source
//   into the clk domain using a toggle req/ack handshake. It double-registers
//   the req toggle and the data bus, waits a settle window, captures the word,
//   pulses a valid strobe and returns an ack toggle to the source. It sits at the
//   fast-side boundary of every slow->fast configuration or status bus.
// PARAMETERS
//   DATA_W      32  width of the transferred word
//   SETTLE_CYC  2   clk cycles spent in SETTLE before capture; legal range >=1
// PORTS
//   clk           in   1       fast clock
//   rst           in   1       asynchronous reset, active high
//   rst_val       in   DATA_W  reset value for the data sync stages and data_o
//   req_tgl_i     in   1       async request toggle; each level change = one word
//   data_i        in   DATA_W  async word; source holds it stable from before its req toggle until it sees ack
//   clr_i         in   1       synchronous clear of overrun_o
//   data_o        out  DATA_W  last captured word
//   data_valid_o  out  1       1-cycle strobe: data_o updated this cycle
//   ack_tgl_o     out  1       ack toggle back to source; toggles once per capture
//   busy_o        out  1       high when FSM is not IDLE
//   overrun_o     out  1       sticky: req edge detected while busy
// BEHAVIOUR
//   Reset (async, rst=1): req sync stages=0, req edge reg=0, data sync stages=rst_val,
//     data_o=rst_val, data_valid_o=0, ack_tgl_o=0, overrun_o=0, FSM=IDLE, cnt=0.
//   req path: req_s1<=req_tgl_i; req_s2<=req_s1; req_s3<=req_s2; edge = req_s2^req_s3.
//   data path: data_s1<=data_i; data_s2<=data_s1 every cycle (no enable).
//   FSM (state register, binary, 3 states):
//     IDLE    : edge -> SETTLE, cnt<=SETTLE_CYC-1; else stay.
//     SETTLE  : cnt==0 -> CAPTURE; else cnt<=cnt-1.
//     CAPTURE : data_o<=data_s2, data_valid_o<=1, ack_tgl_o<=~ack_tgl_o; -> IDLE.
//   data_valid_o is 0 in every cycle except the one following the CAPTURE edge.
//   busy_o = (state!=IDLE), combinational from the state register.
//   Latency: req_tgl_i sampled new at edge T -> data_o/data_valid_o/ack_tgl_o
//     update at edge T+3+SETTLE_CYC. Next edge may be accepted at T+4+SETTLE_CYC.
//   Overrun: edge while state!=IDLE -> overrun_o<=1. The extra toggle is dropped;
//     it is not queued. In-progress transfer completes normally.
//   clr_i and new overrun in the same cycle: set wins (overrun_o stays 1).
//   Edge in the IDLE cycle in which CAPTURE was just left: accepted normally (no overrun).
//   Reset mid-transfer (SETTLE/CAPTURE): immediate return to reset values; no valid,
//     no ack toggle. Source must re-align to ack_tgl_o=0 after reset.
//   cnt width = $clog2(SETTLE_CYC)+1; no wrap possible (loaded, counts down to 0).
// TESTING
//   1 Reset with rst_val=32'hDEAD_BEEF -> data_o=DEADBEEF, ack_tgl_o=0, busy_o=0, valid=0.
//   2 data_i=32'h1234_5678, toggle req at edge 0 (SETTLE_CYC=2) -> valid 1 cycle after
//     edge 5, data_o=12345678, ack_tgl_o=1, busy_o low again after edge 5.
//   3 Source waits for ack, then sends 3 words A5A5A5A5/5A5A5A5A/0 back-to-back ->
//     3 valid strobes in order, ack toggles 3x, overrun_o=0.
//   4 Second req toggle 2 cycles after the first -> overrun_o=1, only first word
//     captured, one ack toggle; clr_i=1 for 1 cycle -> overrun_o=0.
//   5 Assert rst during SETTLE -> no valid, ack_tgl_o=0, data_o=rst_val; fresh req
//     after release completes with normal latency.
//   6 SETTLE_CYC=1 build: req at edge 0 -> capture visible after edge 4; check busy_o timing.

Source files
------------

// File: rtl/iob_s2f_bus_ctrl.sv
// Slow-to-fast word transfer over a toggle req/ack handshake, captured after a settle window.
// Latency: req sampled at edge T -> data_o/data_valid_o/ack_tgl_o at T+3+SETTLE_CYC; extra toggles while busy are dropped and flagged.
module iob_s2f_bus_ctrl #(
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rst_val,
  input  logic              req_tgl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              ack_tgl_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int CNT_W = $clog2(SETTLE_CYC) + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req_s1, req_s2, req_s3;
  logic              req_edge;
  logic [DATA_W-1:0] data_s1, data_s2;

  // Data is re-registered every cycle; the settle window lets it become stable before capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_s1  <= 1'b0;
      req_s2  <= 1'b0;
      req_s3  <= 1'b0;
      data_s1 <= rst_val;
      data_s2 <= rst_val;
    end else begin
      req_s1  <= req_tgl_i;
      req_s2  <= req_s1;
      req_s3  <= req_s2;
      data_s1 <= data_i;
      data_s2 <= data_s1;
    end
  end

  assign req_edge = req_s2 ^ req_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_edge) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (cnt == '0) state_nxt = CAPTURE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o       <= rst_val;
      data_valid_o <= 1'b0;
      ack_tgl_o    <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      data_valid_o <= (state == CAPTURE);
      if (state == CAPTURE) begin
        data_o    <= data_s2;
        ack_tgl_o <= ~ack_tgl_o;
      end
      // A new overrun outranks a simultaneous clear.
      if (req_edge && (state != IDLE)) overrun_o <= 1'b1;
      else if (clr_i)                  overrun_o <= 1'b0;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_iob_s2f_bus_ctrl.sv
// Directed bench for iob_s2f_bus_ctrl: a vector table for single transfers plus hand sequences for corner cases.
module tb_iob_s2f_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rst_val;
  logic        req, req1;
  logic [31:0] data_i;
  logic        clr;
  logic [31:0] dout, dout1;
  logic        valid, valid1, ack, ack1, busy, busy1, ovr, ovr1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int vcnt;

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_ack;
  } vec_t;
  vec_t vecs[4];

  iob_s2f_bus_ctrl #(.DATA_W(32), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst(rst), .rst_val(rst_val), .req_tgl_i(req), .data_i(data_i),
    .clr_i(clr), .data_o(dout), .data_valid_o(valid), .ack_tgl_o(ack),
    .busy_o(busy), .overrun_o(ovr)
  );

  iob_s2f_bus_ctrl #(.DATA_W(32), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .rst_val(rst_val), .req_tgl_i(req1), .data_i(data_i),
    .clr_i(clr), .data_o(dout1), .data_valid_o(valid1), .ack_tgl_o(ack1),
    .busy_o(busy1), .overrun_o(ovr1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    vecs[0] = '{din: 32'h1234_5678, exp_dout: 32'h1234_5678, exp_ack: 1'b1};
    vecs[1] = '{din: 32'hA5A5_A5A5, exp_dout: 32'hA5A5_A5A5, exp_ack: 1'b0};
    vecs[2] = '{din: 32'h5A5A_5A5A, exp_dout: 32'h5A5A_5A5A, exp_ack: 1'b1};
    vecs[3] = '{din: 32'h0000_0000, exp_dout: 32'h0000_0000, exp_ack: 1'b0};

    rst = 1'b1; rst_val = 32'hDEAD_BEEF; req = 1'b0; req1 = 1'b0; data_i = '0; clr = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_data", dout, 32'hDEAD_BEEF);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_ovr", {31'b0, ovr}, 32'd0);
    chk("rst_data1", dout1, 32'hDEAD_BEEF);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {31'b0, valid}, 32'd0);

    // single transfers, each started once the previous ack is seen
    for (int i = 0; i < 4; i++) begin
      data_i = vecs[i].din;
      req    = ~req;
      tick();                                        // e0
      tick(); chk("e1_busy", {31'b0, busy}, 32'd0);  // e1
      tick(); chk("e2_busy", {31'b0, busy}, 32'd1);  // e2
      tick(); tick();                                // e4
      chk("e4_valid", {31'b0, valid}, 32'd0);
      chk("e4_busy", {31'b0, busy}, 32'd1);
      tick();                                        // e5
      chk("e5_valid", {31'b0, valid}, 32'd1);
      chk("e5_data", dout, vecs[i].exp_dout);
      chk("e5_ack", {31'b0, ack}, {31'b0, vecs[i].exp_ack});
      chk("e5_busy", {31'b0, busy}, 32'd0);
      tick();
      chk("e6_valid", {31'b0, valid}, 32'd0);
    end
    chk("b2b_ovr", {31'b0, ovr}, 32'd0);

    // second toggle two cycles after the first; clear in the setting cycle loses
    data_i = 32'h1111_1111;
    req = ~req;
    tick(); tick();                                  // e1
    req = ~req;
    tick(); tick();                                  // e3
    chk("ovr_e3", {31'b0, ovr}, 32'd0);
    clr = 1'b1;
    tick();                                          // e4
    clr = 1'b0;
    chk("ovr_set_wins", {31'b0, ovr}, 32'd1);
    tick();                                          // e5
    chk("ovr_valid", {31'b0, valid}, 32'd1);
    chk("ovr_data", dout, 32'h1111_1111);
    chk("ovr_ack", {31'b0, ack}, 32'd1);
    vcnt = 0;
    repeat (8) begin tick(); vcnt += int'(valid); end
    chk("ovr_dropped", vcnt, 32'd0);
    chk("ovr_ack_hold", {31'b0, ack}, 32'd1);
    chk("ovr_sticky", {31'b0, ovr}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clr", {31'b0, ovr}, 32'd0);

    // next request lands in the IDLE cycle right after CAPTURE
    data_i = 32'h2222_2222;
    req = ~req;
    repeat (4) tick();                               // e3
    req = ~req;
    tick(); tick();                                  // e5
    chk("bnd_valid1", {31'b0, valid}, 32'd1);
    chk("bnd_ack1", {31'b0, ack}, 32'd0);
    repeat (3) tick();                               // e8
    chk("bnd_valid_e8", {31'b0, valid}, 32'd0);
    chk("bnd_busy_e8", {31'b0, busy}, 32'd1);
    tick();                                          // e9
    chk("bnd_valid2", {31'b0, valid}, 32'd1);
    chk("bnd_ack2", {31'b0, ack}, 32'd1);
    chk("bnd_ovr", {31'b0, ovr}, 32'd0);

    // reset in SETTLE
    data_i = 32'h3333_3333;
    req = ~req;
    tick(); tick(); tick();                          // e2
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst_val = 32'hCAFE_F00D;
    rst = 1'b1;
    req = 1'b0;
    #1;
    chk("mid_rst_data", dout, 32'hCAFE_F00D);
    chk("mid_rst_ack", {31'b0, ack}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    vcnt = 0;
    repeat (6) begin tick(); vcnt += int'(valid); end
    chk("mid_no_valid", vcnt, 32'd0);
    chk("mid_ack_still0", {31'b0, ack}, 32'd0);
    data_i = 32'h4444_4444;
    req = ~req;
    repeat (5) tick();                               // e4
    chk("fresh_e4_valid", {31'b0, valid}, 32'd0);
    tick();                                          // e5
    chk("fresh_valid", {31'b0, valid}, 32'd1);
    chk("fresh_data", dout, 32'h4444_4444);
    chk("fresh_ack", {31'b0, ack}, 32'd1);

    // SETTLE_CYC=1 instance
    data_i = 32'h600D_CAFE;
    req1 = 1'b1;
    tick();                                          // e0
    tick(); chk("s1_e1_busy", {31'b0, busy1}, 32'd0);
    tick(); chk("s1_e2_busy", {31'b0, busy1}, 32'd1);
    tick();
    chk("s1_e3_busy", {31'b0, busy1}, 32'd1);
    chk("s1_e3_valid", {31'b0, valid1}, 32'd0);
    tick();                                          // e4
    chk("s1_valid", {31'b0, valid1}, 32'd1);
    chk("s1_data", dout1, 32'h600D_CAFE);
    chk("s1_ack", {31'b0, ack1}, 32'd1);
    chk("s1_e4_busy", {31'b0, busy1}, 32'd0);
    tick();
    chk("s1_e5_valid", {31'b0, valid1}, 32'd0);
    chk("s1_ovr", {31'b0, ovr1}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
